// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order WB stream and a late-result unit.
// Optional conflict-cycle counter enabled by defining WB_PORT_ARB_PERF_EN.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_valid,
  output logic                     pipe_ready,
  input  logic                     pipe_wen,
  input  logic [ADDR_W-1:0]        pipe_rd,
  input  logic [DATA_W-1:0]        pipe_data,
  input  logic                     flush,
  input  logic                     late_valid,
  output logic                     late_ready,
  input  logic [ADDR_W-1:0]        late_rd,
  input  logic [DATA_W-1:0]        late_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [DATA_W+ADDR_W:0]   wb_bypass
`ifdef WB_PORT_ARB_PERF_EN
  ,
  output logic [31:0]              conflict_cnt
`endif
);

  // state    | meaning
  // PIPE_PRI | pipeline wins conflicts, late losses are counted
  // LATE_PRI | late unit has starved long enough and wins the next conflict
  typedef enum logic {PIPE_PRI, LATE_PRI} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_starve_cnt, w_starve_nxt;

  logic w_pipe_req, w_late_req, w_conflict, w_same_rd;
  logic w_grant_pipe, w_grant_late;
  logic w_pipe_wr, w_late_xfer;

  assign w_pipe_req = pipe_valid & pipe_wen & ~flush;
  assign w_late_req = late_valid;
  assign w_conflict = w_pipe_req & w_late_req;
  // The late result is older, so a shared destination must be written by it first.
  assign w_same_rd  = (late_rd == pipe_rd) && (pipe_rd != '0);

  always_comb begin
    w_grant_pipe = w_pipe_req & ~w_late_req;
    w_grant_late = w_late_req & ~w_pipe_req;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    if (w_conflict) begin
      if (w_same_rd || (r_state == LATE_PRI)) w_grant_late = 1'b1;
      else                                    w_grant_pipe = 1'b1;
    end
    // Ready is held low while in reset so nothing is accepted until release.
    pipe_ready  = reset & pipe_valid & ~(w_pipe_req & ~w_grant_pipe);
    late_ready  = reset & w_grant_late;
    w_late_xfer = late_valid & late_ready;
    w_pipe_wr   = w_pipe_req & pipe_ready;
    if (w_late_xfer) begin
      w_starve_nxt = 4'd0;
      w_state_nxt  = PIPE_PRI;
    end else if (w_conflict && w_grant_pipe) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
      if (w_starve_nxt == 4'(STARVE_LIMIT)) w_state_nxt = LATE_PRI;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= PIPE_PRI;
      r_starve_cnt <= 4'd0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_late_xfer) begin
        rf_we    <= (late_rd != '0);
        rf_waddr <= late_rd;
        rf_wdata <= late_data;
      end else if (w_pipe_wr) begin
        rf_we    <= (pipe_rd != '0);
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

  assign wb_bypass = {rf_wdata, rf_waddr, rf_we};

`ifdef WB_PORT_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  conflict_cnt <= '0;
    else if (w_conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter; checks conflict_cnt when WB_PORT_ARB_PERF_EN is defined.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_ready, pipe_wen, flush;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        late_valid, late_ready;
  logic [4:0]  late_rd;
  logic [31:0] late_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [37:0] wb_bypass;
`ifdef WB_PORT_ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  localparam int NONE = 0, PIPE = 1, LATE = 2;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_wen(pipe_wen),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data), .flush(flush),
    .late_valid(late_valid), .late_ready(late_ready),
    .late_rd(late_rd), .late_data(late_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_bypass(wb_bypass)
`ifdef WB_PORT_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus: drive, record the write that must result, check readies mid-cycle.
  task automatic step(input logic pv, input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                      input logic fl, input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic epr, input logic elr, input int wr);
    pipe_valid = pv; pipe_wen = pw; pipe_rd = prd; pipe_data = pd; flush = fl;
    late_valid = lv; late_rd = lrd; late_data = ld;
    if (wr == PIPE) push_wr(prd, pd);
    if (wr == LATE) push_wr(lrd, ld);
    @(negedge clk);
    chk("pipe_ready", 64'(pipe_ready), 64'(epr));
    chk("late_ready", 64'(late_ready), 64'(elr));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0, 0, NONE);
  endtask

  task automatic idle_check_we(input logic exp_we);
    pipe_valid = 0; late_valid = 0; flush = 0;
    @(negedge clk);
    chk("rf_we_idle", 64'(rf_we), 64'(exp_we));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
        chk("wb_bypass", 64'(wb_bypass), 64'({e.d, e.a, 1'b1}));
      end
    end
  end

  initial begin
    reset = 0;
    pipe_valid = 0; pipe_wen = 0; pipe_rd = 0; pipe_data = 0; flush = 0;
    late_valid = 0; late_rd = 0; late_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_bypass", 64'(wb_bypass), 64'd0);
    chk("rst_pipe_ready", 64'(pipe_ready), 64'd0);
    chk("rst_late_ready", 64'(late_ready), 64'd0);
    reset = 1;
    @(posedge clk);
    #1;

    // pipe only
    step(1, 1, 5'd3, 32'h11, 0, 0, 5'd0, 32'd0, 1, 0, PIPE);
    idle(1);
    idle_check_we(0);

    // starvation: four pipe wins, then the late unit is granted
    for (int i = 1; i <= 4; i++)
      step(1, 1, 5'(i), 32'h100 + 32'(i), 0, 1, 5'd9, 32'hAA, 1, 0, PIPE);
    step(1, 1, 5'd5, 32'h105, 0, 1, 5'd9, 32'hAA, 0, 1, LATE);
    for (int i = 5; i <= 8; i++)
      step(1, 1, 5'(i), 32'h100 + 32'(i), 0, 0, 5'd0, 32'd0, 1, 0, PIPE);
    // back in PIPE_PRI: pipe wins the next conflict
    step(1, 1, 5'd10, 32'h10A, 0, 1, 5'd11, 32'hBB, 1, 0, PIPE);
    step(0, 0, 5'd0, 32'd0, 0, 1, 5'd11, 32'hBB, 0, 1, LATE);

    // same destination: late first, then pipe
    step(1, 1, 5'd5, 32'h1, 0, 1, 5'd5, 32'h2, 0, 1, LATE);
    step(1, 1, 5'd5, 32'h1, 0, 0, 5'd0, 32'd0, 1, 0, PIPE);

    // flushed and non-writing pipe never block the late unit
    step(1, 1, 5'd7, 32'h77, 1, 1, 5'd12, 32'hCC, 1, 1, LATE);
    step(1, 0, 5'd7, 32'h77, 0, 1, 5'd13, 32'hDD, 1, 1, LATE);
    idle(2);

    // x0 target accepted without a write
    step(0, 0, 5'd0, 32'd0, 0, 1, 5'd0, 32'hEE, 0, 1, NONE);
    idle_check_we(0);

    // reset during a pending write drops it
    step(0, 0, 5'd0, 32'd0, 0, 1, 5'd14, 32'h5E, 0, 1, NONE);
    chk("pending_we", 64'(rf_we), 64'd1);
    late_rd = 5'd15; late_data = 32'hF0;
    #1 reset = 0;
    #1;
    chk("midrst_rf_we", 64'(rf_we), 64'd0);
    chk("midrst_waddr", 64'(rf_waddr), 64'd0);
    chk("midrst_late_ready", 64'(late_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    push_wr(5'd15, 32'hF0);
    #1;
    chk("release_late_ready", 64'(late_ready), 64'd1);
    @(posedge clk);
    #1;
    late_valid = 0;
    idle(2);

    // six conflict cycles
    for (int i = 1; i <= 4; i++)
      step(1, 1, 5'(i), 32'h200 + 32'(i), 0, 1, 5'd20, 32'h2020, 1, 0, PIPE);
    step(1, 1, 5'd5, 32'h205, 0, 1, 5'd20, 32'h2020, 0, 1, LATE);
    step(1, 1, 5'd5, 32'h205, 0, 1, 5'd21, 32'h2121, 1, 0, PIPE);
    step(0, 0, 5'd0, 32'd0, 0, 1, 5'd21, 32'h2121, 0, 1, LATE);
    idle(2);
`ifdef WB_PORT_ARB_PERF_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'd6);
    #1 reset = 0;
    #2 reset = 1;
    #1;
    chk("conflict_cnt_rst", 64'(conflict_cnt), 64'd0);
`endif
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order pipeline writeback stream;
  - a multi-cycle late-result unit (divider / refilled load).
- Sits between the WB stage output and the regfile write port.
- Resolves conflicts, prevents late-unit starvation, keeps same-register write order and drives the writeback bypass bus.
- Regfile write is registered: one cycle after acceptance.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- STARVE_LIMIT, 4, consecutive conflict losses of the late unit before it gets priority (legal 1..15)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- pipe_valid  input  1  WB stage has an instruction
- pipe_ready  output  1  arbiter accepts the WB instruction this cycle
- pipe_wen  input  1  WB instruction writes a register
- pipe_rd  input  ADDR_W  WB destination register
- pipe_data  input  DATA_W  WB result
- flush  input  1  kill current WB instruction
- late_valid  input  1  late unit holds a result
- late_ready  output  1  arbiter accepts the late result this cycle
- late_rd  input  ADDR_W  late destination register
- late_data  input  DATA_W  late result
- rf_we  output  1  regfile write enable
- rf_waddr  output  ADDR_W  regfile write address
- rf_wdata  output  DATA_W  regfile write data
- wb_bypass  output  DATA_W+ADDR_W+1  {rf_wdata, rf_waddr, rf_we}

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs 0; state PIPE_PRI; starve_cnt 0.
  - Assertion mid-transfer drops any pending registered write.
  - Requesters keep their valid asserted across reset; transfers resume after deassertion.
- Handshake: a transfer occurs when valid and ready are both 1 in the same cycle. Ready is combinational from the valids, pipe_wen, rd values, flush and state.
- Requests:
  - Pipe request = pipe_valid & pipe_wen & ~flush.
  - Late request = late_valid.
  - Conflict = both requests present.
- pipe_valid with pipe_wen=0, or with flush=1: pipe_ready=1 and nothing is written. This never blocks the late unit.
- No conflict: the sole requester is granted (ready=1).
- Conflict resolution, in priority order:
  1. If late_rd == pipe_rd and the register is not 0, grant late (it is older; this preserves write-after-write order), regardless of state.
  2. Otherwise, in state PIPE_PRI grant pipe and increment starve_cnt.
  3. Otherwise, in state LATE_PRI grant late.
- The loser's ready is 0; the loser holds its payload stable.
- State machine:
  - PIPE_PRI -> LATE_PRI when a conflict-loss increment makes starve_cnt == STARVE_LIMIT.
  - LATE_PRI -> PIPE_PRI on a late transfer.
  - Any late transfer clears starve_cnt.
  - Pipe transfers without conflict leave starve_cnt unchanged.
- Output register, loaded on the cycle after a granted write transfer:
  - rf_we=1, rf_waddr = granted rd, rf_wdata = granted data.
  - With no write transfer, rf_we=0 the next cycle; addr/data hold their last value.
- rd = 0: the transfer is accepted but rf_we is forced 0.
- At most one write per cycle; throughput of one write per cycle.
- wb_bypass is a pure concatenation of the registered outputs.

Optional Feature:
- Macro: WB_PORT_ARB_PERF_EN.
- Defined:
  - Extra output port conflict_cnt (32 bits).
  - Counts cycles with a conflict; saturates at 0xFFFFFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Pipe only: pipe rd=3, data=0x11 for one cycle -> pipe_ready=1; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x11; the cycle after, rf_we=0.
- Starvation, STARVE_LIMIT=4: pipe requests rd=1..8 back-to-back; late_valid rd=9, data=0xAA held.
  - Pipe wins 4 conflicts; 5th cycle late_ready=1 and pipe_ready=0.
  - rf write of reg 9 = 0xAA follows.
  - State returns to PIPE_PRI.
- Same-rd conflict: pipe rd=5 data=0x1, late rd=5 data=0x2, state PIPE_PRI -> late granted first.
  - Writes appear as reg5=0x2, then reg5=0x1 one cycle later.
  - starve_cnt unchanged.
- Non-writing / flushed pipe: pipe_wen=0, or flush=1 with late_valid=1 -> pipe_ready=1 and late_ready=1 in the same cycle; only the late write appears.
- x0 and reset: late rd=0 -> late_ready=1 and rf_we stays 0.
  - Then reset low mid-stream with a pending write -> rf_we=0 immediately.
  - After release, a held late_valid is accepted on the first cycle.
- With WB_PORT_ARB_PERF_EN defined: 6 conflict cycles -> conflict_cnt=6; after a reset pulse -> conflict_cnt=0.
